// File: rtl/block_to_stream_if.sv
// Block-in / beat-out handshake bundle for block_to_stream.
// master = block producer + stream consumer side, slave = block_to_stream.
interface block_to_stream_if #(
   parameter int DATA_WIDTH = 32
);
   logic                               in_valid;
   logic                               in_ready;
   logic [7:0][7:0][DATA_WIDTH-1:0]    in_block;
   logic                               out_valid;
   logic                               out_ready;
   logic [DATA_WIDTH-1:0]              out_data;
   logic [5:0]                         out_index;
   logic                               out_last;

   modport master (
      output in_valid, in_block, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      input  in_valid, in_block, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/block_to_stream.sv
// Captures one 8x8 block of words and emits it as 64 valid/ready beats; first beat 1 cycle after capture.
// Backpressure stalls the beat in place; next block is accepted on the final beat. Macro: BLOCK_TO_STREAM_ZIGZAG_EN.
module block_to_stream #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   block_to_stream_if.slave       bus,
   output logic [COUNT_WIDTH-1:0] o_block_count,
   output logic                   o_busy
);

   localparam logic [0:0] ST_EMPTY  = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   typedef logic [7:0][7:0][DATA_WIDTH-1:0] block_t;

`ifdef BLOCK_TO_STREAM_ZIGZAG_EN
   localparam logic [5:0] ZZ_TABLE [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };
`endif

   // Scan position -> row-major element index (r*8+c).
   function automatic logic [5:0] scan_lin(input logic [5:0] pos);
`ifdef BLOCK_TO_STREAM_ZIGZAG_EN
      return ZZ_TABLE[pos];
`else
      return pos;
`endif
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pick(input block_t blk, input logic [5:0] lin);
      return blk[lin[5:3]][lin[2:0]];
   endfunction

   logic [0:0]             r_state;
   logic [5:0]             r_pos;
   logic [DATA_WIDTH-1:0]  r_out_data;
   logic [COUNT_WIDTH-1:0] r_block_count;
   block_t                 r_buf;

   logic                   w_xfer;
   logic                   w_last_xfer;
   logic                   w_in_ready;
   logic                   w_capture;
   logic [5:0]             w_next_pos;

   assign w_xfer      = (r_state == ST_STREAM) & bus.out_ready;
   assign w_last_xfer = w_xfer & (r_pos == 6'd63);
   // Reset blocks capture so a block presented during reset is never taken.
   assign w_in_ready  = ~i_reset & ((r_state == ST_EMPTY) | w_last_xfer);
   assign w_capture   = bus.in_valid & w_in_ready;
   assign w_next_pos  = r_pos + 6'd1;

   always_ff @(posedge i_clock) begin
      if (w_capture) begin
         r_buf <= bus.in_block;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= ST_EMPTY;
         r_pos         <= 6'd0;
         r_out_data    <= '0;
         r_block_count <= '0;
      end else begin
         if (w_capture) begin
            // Buffer is loaded this same edge, so the first beat reads the incoming block.
            r_state    <= ST_STREAM;
            r_pos      <= 6'd0;
            r_out_data <= pick(bus.in_block, scan_lin(6'd0));
         end else if (w_last_xfer) begin
            r_state <= ST_EMPTY;
            r_pos   <= 6'd0;
         end else if (w_xfer) begin
            r_pos      <= w_next_pos;
            r_out_data <= pick(r_buf, scan_lin(w_next_pos));
         end
         if (w_last_xfer) begin
            r_block_count <= r_block_count + COUNT_WIDTH'(1);
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = (r_state == ST_STREAM);
   assign bus.out_data   = r_out_data;
   assign bus.out_index  = r_pos;
   assign bus.out_last   = (r_state == ST_STREAM) & (r_pos == 6'd63);
   assign o_block_count  = r_block_count;
   assign o_busy         = (r_state == ST_STREAM);

endmodule
